wb_rr_arbiter: RTL and testbench
================================

// Module: wb_rr_arbiter
// PURPOSE
// - Two-requester round-robin arbiter sharing one Wishbone master bus to the I2CMB slave port
//   (ADDR_WIDTH=2: CSR/DPR/CMDR/FSMR).
// - Lets two test agents (e.g. a command sequencer and a register poller) drive one DUT.
// - Routes the DUT interrupt to the requester that owns the bus.
// PARAMETERS
// - ADDR_WIDTH      2   Wishbone address width
// - DATA_WIDTH      8   Wishbone data width
// - TIMEOUT_CYCLES  64  stalled-cycle limit before abort; used only with WB_ARB_TIMEOUT_EN
// PORTS
// - clk_i      in   1           system clock, all logic on rising edge
// - rst_n_i    in   1           reset, asynchronous, active-low
// - mN_cyc_i   in   1           requester N (N=0,1) cycle request; held high to keep bus locked
// - mN_stb_i   in   1           requester N strobe
// - mN_we_i    in   1           requester N write enable
// - mN_adr_i   in   ADDR_WIDTH  requester N address
// - mN_dat_i   in   DATA_WIDTH  requester N write data
// - mN_dat_o   out  DATA_WIDTH  read data to requester N (= s_dat_i, broadcast to both)
// - mN_ack_o   out  1           ack to requester N
// - mN_err_o   out  1           timeout abort to requester N
// - mN_irq_o   out  1           interrupt to requester N
// - s_cyc_o    out  1           slave cycle
// - s_stb_o    out  1           slave strobe
// - s_we_o     out  1           slave write enable
// - s_adr_o    out  ADDR_WIDTH  slave address
// - s_dat_o    out  DATA_WIDTH  slave write data
// - s_dat_i    in   DATA_WIDTH  slave read data
// - s_ack_i    in   1           slave ack
// - irq_i      in   1           DUT interrupt
// BEHAVIOUR
// - One clock, clk_i. Reset is asynchronous and active-low on rst_n_i.
// - FSM states: IDLE, GNT0, GNT1, ABORT (ABORT exists only with WB_ARB_TIMEOUT_EN).
// - Reset: state=IDLE, last_grant=1, irq_owner=0, every output 0.
//   rst_n_i low mid-transfer drops s_cyc_o/s_stb_o immediately.
// - IDLE:
//   - s_cyc_o/s_stb_o/s_we_o=0; s_adr_o/s_dat_o=0.
//   - Only m0_cyc_i set -> GNT0. Only m1_cyc_i set -> GNT1.
//   - Both set -> grant the requester != last_grant.
//   - On grant: last_grant and irq_owner load the granted index.
// - Arbitration latency: 1 cycle. Request seen in IDLE; slave signals driven from the next cycle.
// - GNTn:
//   - s_* outputs are combinational from requester n's cyc/stb/we/adr/dat.
//   - mn_ack_o = s_ack_i. Non-owner ack is 0.
//   - A non-owner request stalls with no ack.
// - Release: owner mn_cyc_i low -> IDLE. IDLE lasts at least 1 cycle, giving an idle gap between owners.
// - Lock: owner keeps cyc high across several stb pulses; no preemption while cyc is high.
// - Same-cycle cases:
//   - s_ack_i together with owner cyc drop: ack still passed, then release.
//   - Both requests on release: next grant goes to the other requester.
// - mN_irq_o = irq_i & (irq_owner==N). irq_owner survives release; it is updated only on a new grant.
// CONFIGURATION
// - `WB_ARB_TIMEOUT_EN defined:
//   - Counter (clog2(TIMEOUT_CYCLES+1) bits) counts owner cycles with s_stb_o=1 and s_ack_i=0.
//   - Counter clears on ack or on leaving GNTn.
//   - Count reaching TIMEOUT_CYCLES: mn_err_o=1 for 1 cycle, s_cyc_o/s_stb_o=0, state -> ABORT.
//   - ABORT holds until owner cyc_i is low, then -> IDLE.
// - Not defined: no counter, no ABORT state, mN_err_o tied 0, a stalled transfer waits forever.
// TESTING
// - Reset, then m0 writes adr=2'd0 dat=8'hC0 -> s_cyc_o rises 1 clk after m0_cyc_i, s_adr_o=0,
//   s_dat_o=C0, m0_ack_o on s_ack_i.
// - m0 and m1 raise cyc in the same cycle, repeated 4 times -> grants alternate 0,1,0,1;
//   s_cyc_o low for >=1 clk between owners.
// - m1 locked (cyc held) doing write CMDR=8'h04 then 3 reads of CMDR while m0 requests ->
//   m0 gets no ack until m1 drops cyc; m1 reads return s_dat_i.
// - irq_i pulses after m1's transfer while both are idle -> m1_irq_o=1, m0_irq_o=0.
// - rst_n_i pulled low mid-GNT0 with stb high -> s_cyc_o=0 asynchronously; after reset,
//   simultaneous requests grant m0 first.
// - With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never acks -> m0_err_o=1 after 8 stalled
//   cycles, s_cyc_o=0; m1 is granted after m0 drops cyc.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter
// Two-requester round-robin arbiter that shares one Wishbone master bus
// towards the I2CMB slave port (CSR/DPR/CMDR/FSMR). The DUT interrupt is
// routed to the requester that was granted most recently.
//
// Optional feature macro: WB_ARB_TIMEOUT_EN
//   When defined, a stalled-transfer counter aborts the owner after
//   TIMEOUT_CYCLES unacknowledged strobe cycles. The owner sees a one-cycle
//   err pulse, and the bus stays parked in ABORT until the owner drops cyc.
//   When undefined, there is no counter and mN_err_o is tied to 0.
//
// Ports
//   clk_i, rst_n_i       clock, asynchronous active-low reset
//   mN_cyc/stb/we/adr/dat_i  requester N (N=0,1) Wishbone master inputs
//   mN_dat_o             read data to requester N (broadcast of s_dat_i)
//   mN_ack_o             ack to requester N (owner only)
//   mN_err_o             timeout abort to requester N
//   mN_irq_o             interrupt to requester N (irq owner only)
//   s_cyc/stb/we/adr/dat_o   slave-side Wishbone outputs
//   s_dat_i, s_ack_i     slave read data / ack
//   irq_i                DUT interrupt
// ---------------------------------------------------------------------------
module wb_rr_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 2,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,

    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_dat_i,
    output logic [DATA_WIDTH-1:0] m0_dat_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    output logic                  m0_irq_o,

    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    output logic [DATA_WIDTH-1:0] m1_dat_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic                  m1_irq_o,

    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    input  logic                  s_ack_i,

    input  logic                  irq_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT0  = 2'd1,
        ST_GNT1  = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   last_grant_q;
    logic   irq_owner_q;
    logic   grant_load_c;
    logic   grant_idx_c;
    logic   timeout_c;

    // A zero limit would abort every transfer on its first cycle.
    if (TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("wb_rr_arbiter: TIMEOUT_CYCLES must be nonzero");
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] stall_cnt_q;
    logic             in_gnt_c;

    assign in_gnt_c  = (state_q == ST_GNT0) || (state_q == ST_GNT1);
    assign timeout_c = in_gnt_c && (stall_cnt_q == CNT_W'(TIMEOUT_CYCLES));

    // Stall counter: owner strobing without ack; cleared on ack or state change.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_q <= '0;
        end else if (state_d != state_q || s_ack_i || !in_gnt_c) begin
            stall_cnt_q <= '0;
        end else if (s_stb_o && !timeout_c) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end
`else
    assign timeout_c = 1'b0;
`endif

    // State register plus grant history; both load only when a grant is issued.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            irq_owner_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_load_c) begin
                last_grant_q <= grant_idx_c;
                irq_owner_q  <= grant_idx_c;
            end
        end
    end

    // Next-state: round-robin pick in IDLE, hold while owner keeps cyc.
    always_comb begin
        state_d      = state_q;
        grant_load_c = 1'b0;
        grant_idx_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    grant_load_c = 1'b1;
                    grant_idx_c  = ~last_grant_q;
                end else if (m0_cyc_i) begin
                    grant_load_c = 1'b1;
                    grant_idx_c  = 1'b0;
                end else if (m1_cyc_i) begin
                    grant_load_c = 1'b1;
                    grant_idx_c  = 1'b1;
                end
                if (grant_load_c) begin
                    state_d = grant_idx_c ? ST_GNT1 : ST_GNT0;
                end
            end
            ST_GNT0: begin
                if (!m0_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (timeout_c) begin
                    state_d = ST_ABORT;
                end
            end
            ST_GNT1: begin
                if (!m1_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (timeout_c) begin
                    state_d = ST_ABORT;
                end
            end
`ifdef WB_ARB_TIMEOUT_EN
            ST_ABORT: begin
                // Park until the aborted owner lets go of the bus.
                if (!(last_grant_q ? m1_cyc_i : m0_cyc_i)) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode: slave bus mirrors the owner; abort cycle drops cyc/stb.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_err_o = 1'b0;
        case (state_q)
            ST_GNT0: begin
                s_we_o  = m0_we_i;
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
                if (timeout_c) begin
                    m0_err_o = 1'b1;
                end else begin
                    s_cyc_o  = m0_cyc_i;
                    s_stb_o  = m0_stb_i;
                    m0_ack_o = s_ack_i;
                end
            end
            ST_GNT1: begin
                s_we_o  = m1_we_i;
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
                if (timeout_c) begin
                    m1_err_o = 1'b1;
                end else begin
                    s_cyc_o  = m1_cyc_i;
                    s_stb_o  = m1_stb_i;
                    m1_ack_o = s_ack_i;
                end
            end
            default: begin
            end
        endcase
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // Interrupt follows the most recent grant, surviving release.
    assign m0_irq_o = irq_i & ~irq_owner_q;
    assign m1_irq_o = irq_i &  irq_owner_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_rr_arbiter
// Directed bench for wb_rr_arbiter: single write, round-robin alternation,
// bus lock with a competing requester, irq routing, asynchronous reset
// mid-transfer and (with WB_ARB_TIMEOUT_EN) stall abort.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit
// later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_wb_rr_arbiter;

    localparam int unsigned AW = 2;
    localparam int unsigned DW = 8;
    localparam int unsigned TO = 8;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          m0_cyc_i, m0_stb_i, m0_we_i;
    logic [AW-1:0] m0_adr_i;
    logic [DW-1:0] m0_dat_i, m0_dat_o;
    logic          m0_ack_o, m0_err_o, m0_irq_o;
    logic          m1_cyc_i, m1_stb_i, m1_we_i;
    logic [AW-1:0] m1_adr_i;
    logic [DW-1:0] m1_dat_i, m1_dat_o;
    logic          m1_ack_o, m1_err_o, m1_irq_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o, s_dat_i;
    logic          s_ack_i, irq_i;

    int n_checks = 0;
    int n_pass   = 0;
    logic tb_last;

    wb_rr_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .m0_cyc_i (m0_cyc_i),
        .m0_stb_i (m0_stb_i),
        .m0_we_i  (m0_we_i),
        .m0_adr_i (m0_adr_i),
        .m0_dat_i (m0_dat_i),
        .m0_dat_o (m0_dat_o),
        .m0_ack_o (m0_ack_o),
        .m0_err_o (m0_err_o),
        .m0_irq_o (m0_irq_o),
        .m1_cyc_i (m1_cyc_i),
        .m1_stb_i (m1_stb_i),
        .m1_we_i  (m1_we_i),
        .m1_adr_i (m1_adr_i),
        .m1_dat_i (m1_dat_i),
        .m1_dat_o (m1_dat_o),
        .m1_ack_o (m1_ack_o),
        .m1_err_o (m1_err_o),
        .m1_irq_o (m1_irq_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_we_o   (s_we_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i),
        .irq_i    (irq_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_all();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0; m0_adr_i = '0; m0_dat_i = '0;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0; m1_adr_i = '0; m1_dat_i = '0;
        s_ack_i  = 1'b0; s_dat_i  = '0;
    endtask

    initial begin
        rst_n_i = 1'b0;
        irq_i   = 1'b0;
        tb_last = 1'b1;
        idle_all();

        // ---- reset state
        #12;
        check("rst_s_cyc", 32'(s_cyc_o), 32'd0);
        check("rst_s_stb", 32'(s_stb_o), 32'd0);
        check("rst_ack",   32'({m0_ack_o, m1_ack_o}), 32'd0);
        check("rst_err",   32'({m0_err_o, m1_err_o}), 32'd0);
        check("rst_irq",   32'({m0_irq_o, m1_irq_o}), 32'd0);
        rst_n_i = 1'b1;

        // ---- m0 single write CSR <= C0, 1-cycle arbitration latency
        tick();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1; m0_adr_i = 2'd0; m0_dat_i = 8'hC0;
        #1;
        check("wr_latency_cyc", 32'(s_cyc_o), 32'd0);
        tick();
        #1;
        check("wr_s_cyc", 32'(s_cyc_o), 32'd1);
        check("wr_s_we",  32'(s_we_o),  32'd1);
        check("wr_s_adr", 32'(s_adr_o), 32'd0);
        check("wr_s_dat", 32'(s_dat_o), 32'hC0);
        check("wr_noack", 32'(m0_ack_o), 32'd0);
        s_ack_i = 1'b1;
        #1;
        check("wr_m0_ack", 32'(m0_ack_o), 32'd1);
        check("wr_m1_ack", 32'(m1_ack_o), 32'd0);
        tick();
        idle_all();
        #1;
        check("wr_release_cyc", 32'(s_cyc_o), 32'd0);
        tick();
        tb_last = 1'b0;

        // ---- reset pulled mid-GNT0 with stb high
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_dat_i = 8'h55;
        tick();
        #1;
        check("rstmid_cyc_before", 32'(s_cyc_o), 32'd1);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("rstmid_cyc_async", 32'(s_cyc_o), 32'd0);
        check("rstmid_stb_async", 32'(s_stb_o), 32'd0);
        idle_all();
        tick();
        rst_n_i = 1'b1;
        tb_last = 1'b1;
        tick();

        // ---- simultaneous requests, 4 rounds: grants alternate starting at m0
        for (int r = 0; r < 4; r++) begin
            logic exp_owner;
            exp_owner = ~tb_last;
            m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_dat_i = 8'(8'h10 + r);
            m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_dat_i = 8'(8'h20 + r);
            #1;
            check("rr_latency_cyc", 32'(s_cyc_o), 32'd0);
            tick();
            s_ack_i = 1'b1;
            #1;
            check("rr_s_dat", 32'(s_dat_o), exp_owner ? 32'(8'h20 + r) : 32'(8'h10 + r));
            check("rr_m0_ack", 32'(m0_ack_o), exp_owner ? 32'd0 : 32'd1);
            check("rr_m1_ack", 32'(m1_ack_o), exp_owner ? 32'd1 : 32'd0);
            tb_last = exp_owner;
            tick();
            idle_all();
            #1;
            check("rr_gap0_cyc", 32'(s_cyc_o), 32'd0);
            tick();
            check("rr_gap1_cyc", 32'(s_cyc_o), 32'd0);
        end

        // ---- m1 locked: write CMDR=04 then 3 reads, m0 requesting throughout
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_adr_i = 2'd2; m1_dat_i = 8'h04;
        tick();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0; m0_adr_i = 2'd3;
        s_ack_i = 1'b1;
        #1;
        check("lock_wr_adr",  32'(s_adr_o), 32'd2);
        check("lock_wr_dat",  32'(s_dat_o), 32'h04);
        check("lock_wr_ack1", 32'(m1_ack_o), 32'd1);
        check("lock_wr_ack0", 32'(m0_ack_o), 32'd0);
        tick();
        m1_stb_i = 1'b0; s_ack_i = 1'b0;
        #1;
        check("lock_hold_cyc", 32'(s_cyc_o), 32'd1);
        check("lock_hold_stb", 32'(s_stb_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            m1_stb_i = 1'b1; m1_we_i = 1'b0; s_dat_i = 8'(8'hA0 + i); s_ack_i = 1'b1;
            #1;
            check("lock_rd_we",   32'(s_we_o),   32'd0);
            check("lock_rd_ack1", 32'(m1_ack_o), 32'd1);
            check("lock_rd_dat",  32'(m1_dat_o), 32'(8'hA0 + i));
            check("lock_rd_ack0", 32'(m0_ack_o), 32'd0);
            tick();
            m1_stb_i = 1'b0; s_ack_i = 1'b0;
        end
        m1_cyc_i = 1'b0;
        #1;
        check("lock_rel_cyc", 32'(s_cyc_o), 32'd0);
        tick();
        check("lock_gap_cyc", 32'(s_cyc_o), 32'd0);
        tick();
        s_ack_i = 1'b1;
        #1;
        check("lock_m0_adr", 32'(s_adr_o), 32'd3);
        check("lock_m0_ack", 32'(m0_ack_o), 32'd1);
        tick();
        idle_all();
        tick();

        // ---- m1 lone transfer, then irq while both idle
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        s_ack_i = 1'b1;
        #1;
        check("irq_pre_ack1", 32'(m1_ack_o), 32'd1);
        tick();
        idle_all();
        tick();
        tick();
        irq_i = 1'b1;
        #1;
        check("irq_m1", 32'(m1_irq_o), 32'd1);
        check("irq_m0", 32'(m0_irq_o), 32'd0);
        tick();
        irq_i = 1'b0;
        #1;
        check("irq_m1_low", 32'(m1_irq_o), 32'd0);
        tick();

`ifdef WB_ARB_TIMEOUT_EN
        // ---- stalled slave: m0 aborted after TO stalled cycles, then m1 served
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        tick();
        for (int i = 0; i < int'(TO); i++) begin
            #1;
            check("to_stall_err", 32'(m0_err_o), 32'd0);
            check("to_stall_cyc", 32'(s_cyc_o), 32'd1);
            tick();
        end
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        #1;
        check("to_err",     32'(m0_err_o), 32'd1);
        check("to_err_cyc", 32'(s_cyc_o),  32'd0);
        check("to_err_m1",  32'(m1_err_o), 32'd0);
        tick();
        check("to_abort_err", 32'(m0_err_o), 32'd0);
        check("to_abort_cyc", 32'(s_cyc_o),  32'd0);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();
        check("to_idle_cyc", 32'(s_cyc_o), 32'd0);
        tick();
        s_ack_i = 1'b1;
        #1;
        check("to_m1_cyc", 32'(s_cyc_o),  32'd1);
        check("to_m1_ack", 32'(m1_ack_o), 32'd1);
        tick();
        idle_all();
        tick();
`else
        // ---- no timeout: a stalled transfer keeps the bus and never errors
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        tick();
        repeat (3 * TO) tick();
        check("noto_err", 32'(m0_err_o), 32'd0);
        check("noto_cyc", 32'(s_cyc_o),  32'd1);
        idle_all();
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
